// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 command transmitter.
//   Sends one command byte to the keyboard over the shared open-drain lines:
//   request-to-send (clock inhibit), start bit, 8 data bits LSB first, odd
//   parity, stop bit, then checks the device acknowledge. A watchdog aborts
//   the frame if the device stops clocking.
// Ports:
//   clk           system clock
//   reset         synchronous, active-high
//   wr_ps2        one-cycle write strobe, accepted only while tx_idle=1
//   din[7:0]      command byte captured on an accepted write
//   ps2d, ps2c    open-drain PS/2 data / clock (driven 0 or released)
//   tx_idle       high while idle; gates the companion receiver
//   tx_done_tick  one-cycle pulse at the end of every frame (good or failed)
//   tx_err        result of the last frame (1 = no ack or timeout)
module ps2_tx #(
  parameter int unsigned RTS_CYCLES     = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2d,
  inout  wire        ps2c,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err
);

  localparam int unsigned RTS_W = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FRM_W = 9;
  localparam int unsigned N_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RTS,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [FRM_W-1:0]     r_frame;
  logic [N_W-1:0]       r_n;
  logic [RTS_W-1:0]     r_rts_cnt;
  logic [WD_W-1:0]      r_wd;
  logic [FILTER_LEN-1:0] r_filt;
  logic                 r_fc;
  logic                 r_fc_prev;
  logic [1:0]           r_d_sync;
  logic                 r_ps2c_low;
  logic                 r_ps2d_low;
  logic                 r_tx_idle;
  logic                 r_done;
  logic                 r_err;

  state_t               w_state_nxt;
  logic [FRM_W-1:0]     w_frame_nxt;
  logic [N_W-1:0]       w_n_nxt;
  logic [RTS_W-1:0]     w_rts_nxt;
  logic [WD_W-1:0]      w_wd_nxt;
  logic                 w_err_nxt;
  logic                 w_fall;
  logic                 w_timeout;

  // Open-drain pads: only ever pull low or release.
  assign ps2c = r_ps2c_low ? 1'b0 : 1'bz;
  assign ps2d = r_ps2d_low ? 1'b0 : 1'bz;

  assign tx_idle      = r_tx_idle;
  assign tx_done_tick = r_done;
  assign tx_err       = r_err;

  // Clock glitch filter with hysteresis, edge register and data synchronizer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_filt    <= '1;
      r_fc      <= 1'b1;
      r_fc_prev <= 1'b1;
      r_d_sync  <= 2'b11;
    end else begin
      r_filt    <= {ps2c, r_filt[FILTER_LEN-1:1]};
      r_fc_prev <= r_fc;
      r_d_sync  <= {r_d_sync[0], ps2d};
      if (&r_filt) begin
        r_fc <= 1'b1;
      end else if (~|r_filt) begin
        r_fc <= 1'b0;
      end
    end
  end

  assign w_fall    = r_fc_prev & ~r_fc;
  assign w_timeout = ~w_fall && (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

  // Next-state logic; watchdog runs in every device-clocked state.
  always_comb begin
    w_state_nxt = r_state;
    w_frame_nxt = r_frame;
    w_n_nxt     = r_n;
    w_rts_nxt   = r_rts_cnt;
    w_wd_nxt    = r_wd;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (wr_ps2) begin
          w_frame_nxt = {~^din, din};
          w_err_nxt   = 1'b0;
          w_rts_nxt   = RTS_W'(RTS_CYCLES - 1);
          w_n_nxt     = '0;
          w_state_nxt = S_RTS;
        end
      end
      S_RTS: begin
        if (r_rts_cnt == '0) begin
          w_wd_nxt    = '0;
          w_state_nxt = S_START;
        end else begin
          w_rts_nxt = r_rts_cnt - RTS_W'(1);
        end
      end
      S_START, S_DATA, S_STOP: begin
        if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else if (w_fall) begin
          w_wd_nxt = '0;
          if (r_state == S_START) begin
            w_n_nxt     = '0;
            w_state_nxt = S_DATA;
          end else if (r_state == S_DATA) begin
            if (r_n == N_W'(8)) begin
              w_state_nxt = S_STOP;
            end else begin
              w_frame_nxt = {1'b1, r_frame[FRM_W-1:1]};
              w_n_nxt     = r_n + N_W'(1);
            end
          end else begin
            // Ack: device holds data low at the final falling edge.
            w_err_nxt   = r_d_sync[1];
            w_state_nxt = S_DONE;
          end
        end else begin
          w_wd_nxt = r_wd + WD_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_frame    <= '0;
      r_n        <= '0;
      r_rts_cnt  <= '0;
      r_wd       <= '0;
      r_err      <= 1'b0;
      r_ps2c_low <= 1'b0;
      r_ps2d_low <= 1'b0;
      r_tx_idle  <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_frame    <= w_frame_nxt;
      r_n        <= w_n_nxt;
      r_rts_cnt  <= w_rts_nxt;
      r_wd       <= w_wd_nxt;
      r_err      <= w_err_nxt;
      r_ps2c_low <= (w_state_nxt == S_RTS);
      r_ps2d_low <= (w_state_nxt == S_START) ||
                    ((w_state_nxt == S_DATA) && !w_frame_nxt[0]);
      r_tx_idle  <= (w_state_nxt == S_IDLE);
      r_done     <= (w_state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: directed bench for ps2_tx with a behavioural PS/2 device.
// System clock is 1 MHz so one 40 us device clock spans 40 clk cycles.
`timescale 1ns/1ps
module tb_ps2_tx;

  localparam int unsigned RTS = 20;
  localparam int unsigned TMO = 500;
  localparam time CLK_HALF = 500;
  localparam time DEV_HALF = 20000;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_ps2;
  logic [7:0] din;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       tx_err;
  logic       dev_c_low;
  logic       dev_d_low;
  wire        ps2c;
  wire        ps2d;

  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt = 0;
  logic last_err;

  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d = dev_d_low ? 1'b0 : 1'bz;

  ps2_tx #(
    .RTS_CYCLES    (RTS),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_ps2      (wr_ps2),
    .din         (din),
    .ps2d        (ps2d),
    .ps2c        (ps2c),
    .tx_idle     (tx_idle),
    .tx_done_tick(tx_done_tick),
    .tx_err      (tx_err)
  );

  always #CLK_HALF clk = ~clk;

  // Done-pulse monitor: counts pulses and latches the error alongside each.
  always @(negedge clk) begin
    if (tx_done_tick === 1'b1) begin
      done_cnt = done_cnt + 1;
      last_err = tx_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_cmd(input logic [7:0] b);
    @(negedge clk);
    wr_ps2 = 1'b1;
    din    = b;
    @(negedge clk);
    wr_ps2 = 1'b0;
  endtask

  // Counts clk cycles with ps2c held low; optionally fires a stray write.
  task automatic wait_rts(output int lowcnt, input bit inj);
    lowcnt = 0;
    for (int i = 0; i < 1000; i++) begin
      if (ps2c !== 1'b0) break;
      lowcnt++;
      if (inj && lowcnt == 5) begin
        wr_ps2 = 1'b1;
        din    = 8'h55;
      end else begin
        wr_ps2 = 1'b0;
      end
      @(negedge clk);
    end
    wr_ps2 = 1'b0;
  endtask

  // Device: samples start before F1, then data on each rising edge.
  task automatic dev_frame(input int nfall, input bit ack, output logic [10:0] smp);
    smp = '0;
    #(DEV_HALF / 2);
    smp[0] = ps2d;
    for (int i = 1; i <= 10; i++) begin
      if (i <= nfall) begin
        dev_c_low = 1'b1;
        #DEV_HALF;
        dev_c_low = 1'b0;
        smp[i] = ps2d;
        if (i == 10 && ack) dev_d_low = 1'b1;
        #DEV_HALF;
      end
    end
    if (nfall >= 11) begin
      dev_c_low = 1'b1;
      #DEV_HALF;
      dev_c_low = 1'b0;
      #(DEV_HALF / 2);
      dev_d_low = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input logic par, input bit ack,
                           input bit inj, input string tag);
    int          base;
    int          lowcnt;
    logic [10:0] smp;
    logic [10:0] exp_frm;
    base     = done_cnt;
    last_err = 1'bx;
    exp_frm  = {1'b1, par, b, 1'b0};
    write_cmd(b);
    chk($sformatf("%s_busy", tag), 32'(tx_idle), 32'd0);
    wait_rts(lowcnt, inj);
    chk($sformatf("%s_rts_len", tag), 32'(lowcnt), 32'(RTS));
    chk($sformatf("%s_start_d", tag), 32'(ps2d), 32'd0);
    dev_frame(11, ack, smp);
    chk($sformatf("%s_bits", tag), 32'(smp), 32'(exp_frm));
    repeat (30) @(negedge clk);
    chk($sformatf("%s_done_cnt", tag), 32'(done_cnt - base), 32'd1);
    chk($sformatf("%s_err", tag), 32'(last_err), 32'(!ack));
    chk($sformatf("%s_idle", tag), 32'(tx_idle), 32'd1);
    chk($sformatf("%s_lines", tag), 32'({ps2c, ps2d}), 32'd3);
  endtask

  initial begin
    int          lowcnt;
    int          cnt;
    int          base;
    logic [10:0] smp;

    reset     = 1'b1;
    wr_ps2    = 1'b0;
    din       = 8'h00;
    dev_c_low = 1'b0;
    dev_d_low = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_idle", 32'(tx_idle), 32'd1);
    chk("rst_tick", 32'(tx_done_tick), 32'd0);
    chk("rst_err", 32'(tx_err), 32'd0);
    chk("rst_lines", 32'({ps2c, ps2d}), 32'd3);
    reset = 1'b0;
    repeat (12) @(negedge clk);

    // Normal frames with ack; parity is odd over the byte.
    run_frame(8'hED, 1'b1, 1'b1, 1'b0, "ed");
    run_frame(8'hF4, 1'b0, 1'b1, 1'b0, "f4");
    run_frame(8'h00, 1'b1, 1'b1, 1'b0, "x00");
    run_frame(8'hFF, 1'b1, 1'b1, 1'b0, "xff");

    // Device withholds ack.
    run_frame(8'hED, 1'b1, 1'b0, 1'b0, "noack");

    // Device never clocks: watchdog fires TMO cycles after start entry.
    write_cmd(8'hA5);
    wait_rts(lowcnt, 1'b0);
    chk("tmo_rts_len", 32'(lowcnt), 32'(RTS));
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      cnt++;
      if (tx_done_tick === 1'b1) break;
    end
    chk("tmo_cycles", 32'(cnt), 32'(TMO));
    chk("tmo_err", 32'(tx_err), 32'd1);
    chk("tmo_d_rel", 32'(ps2d), 32'd1);
    @(negedge clk);
    chk("tmo_idle", 32'(tx_idle), 32'd1);
    chk("tmo_c_rel", 32'(ps2c), 32'd1);
    repeat (12) @(negedge clk);

    // Stray write of 0x55 during an 0xED frame is ignored.
    run_frame(8'hED, 1'b1, 1'b1, 1'b1, "inj");
    base = done_cnt;
    repeat (50) @(negedge clk);
    chk("inj_no_extra", 32'(done_cnt - base), 32'd0);
    chk("inj_c_rel", 32'(ps2c), 32'd1);

    // Reset mid-frame after F5 (bit4 of 0xED is 0, so data is held low).
    write_cmd(8'hED);
    wait_rts(lowcnt, 1'b0);
    base = done_cnt;
    dev_frame(5, 1'b0, smp);
    @(negedge clk);
    chk("mid_d_low", 32'(ps2d), 32'd0);
    chk("mid_busy", 32'(tx_idle), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_lines", 32'({ps2c, ps2d}), 32'd3);
    chk("mid_rst_idle", 32'(tx_idle), 32'd1);
    chk("mid_rst_err", 32'(tx_err), 32'd0);
    chk("mid_rst_tick", 32'(tx_done_tick), 32'd0);
    repeat (12) @(negedge clk);
    chk("mid_no_done", 32'(done_cnt - base), 32'd0);
    run_frame(8'hF4, 1'b0, 1'b1, 1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_tx.md
# ps2_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) to the keyboard over the shared open-drain ps2d/ps2c lines. It performs the host request-to-send sequence, shifts out data and odd parity on device-generated clock edges, and checks the device acknowledge. It sits beside the PS/2 receiver on the same pins. The top level gates the receiver enable with `tx_idle` so the receiver ignores the host's own frame.

## Interface
- `RTS_CYCLES`, default 5000: clock-low inhibit time in clk cycles (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 1000000: maximum clk cycles between device falling edges before abort (20 ms).
- `FILTER_LEN`, default 8: ps2c glitch-filter depth in samples.
- `clk`, input, 1: system clock; the only clock.
- `reset`, input, 1: synchronous, active-high.
- `wr_ps2`, input, 1: one-cycle write strobe; accepted only when `tx_idle`=1.
- `din`, input, 8: command byte, captured on an accepted `wr_ps2`.
- `ps2d`, inout, 1: PS/2 data, open-drain (drive 0 or Z, never 1).
- `ps2c`, inout, 1: PS/2 clock, open-drain.
- `tx_idle`, output, 1: high in `idle`.
- `tx_done_tick`, output, 1: one-cycle pulse at the end of a frame, whether it succeeded or failed.
- `tx_err`, output, 1: result of the last frame (1 = missing ack or timeout); holds its value until the next accepted write.

## Operation
- Input conditioning:
  - ps2c is sampled into a `FILTER_LEN` shift register. The filtered clock goes to 1 when all samples are 1 and to 0 when all are 0; otherwise it holds.
  - `fall_edge` = filtered clock was 1 last cycle and is 0 now.
  - ps2d passes through a two-flop synchronizer.
- Frame register: 9 bits holding {parity, din}. Parity = ~^din (odd). Bit count n is 4 bits.
- States:
  - `idle`: both lines released. On `wr_ps2`: load frame, clear `tx_err`, load the RTS counter, go to `rts`.
  - `rts`: drive ps2c=0, ps2d released, for exactly `RTS_CYCLES` cycles. Then go to `start`.
  - `start`: drive ps2d=0 and release ps2c. On `fall_edge` (F1), go to `data` with n=0.
  - `data`: drive ps2d=0 when frame[0]=0, otherwise release it. On `fall_edge`: if n==8, go to `stop`; else shift the frame right and increment n. F2 through F10 are consumed here, so bit0 through bit7 and parity are each presented for one device clock.
  - `stop`: ps2d released (this is the stop bit). On `fall_edge` (F11), sample synchronized ps2d: 0 means ack. Set `tx_err` = sampled value and go to `done`.
  - `done`: pulse `tx_done_tick` and go to `idle`.
- Watchdog:
  - The counter clears on entry to `start` and on every `fall_edge`, and increments in `start`, `data` and `stop`.
  - When it reaches `TIMEOUT_CYCLES`: set `tx_err`=1, release both lines, go to `done`.
- `wr_ps2` while not idle is ignored; `din` is not re-captured.
- Reset, any cycle including mid-frame: state `idle`, both lines released, `tx_idle`=1, `tx_done_tick`=0, `tx_err`=0, counters 0.

## Timing
- Accepted write at cycle T: `tx_idle`=0 and ps2c driven low from T+1.
- ps2c stays low for `RTS_CYCLES` cycles, then ps2d goes low and ps2c is released in the same cycle.
- The data line changes 1 cycle after each detected `fall_edge`. Detection lags the pin by `FILTER_LEN` cycles (filter) plus 1 cycle (edge register).
- After F11 is detected: `tx_done_tick` fires the next cycle; `tx_idle` returns to 1 the cycle after that.
- `tx_err` is valid in the same cycle as `tx_done_tick`.
- The block never drives a line to 1, and never drives ps2c outside `rts`.

## Test plan
Bench settings: `RTS_CYCLES`=20, `TIMEOUT_CYCLES`=500. Device model uses a 40 µs clock period, samples data on the rising edge, and drives the ack.

1. Write 0xED, device acks → ps2c low for 20 cycles; device samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1 → `tx_done_tick` pulses once with `tx_err`=0.
2. Write 0xF4 → sampled bits 0,0,1,0,1,1,1,1, parity 0; ack → `tx_err`=0. Repeat with 0x00 and with 0xFF → parity 1 in both cases.
3. Device does not ack (ps2d high at F11) → `tx_err`=1, `tx_done_tick` pulses, both lines released.
4. Device never clocks after RTS → 500 cycles after entering `start`: `tx_err`=1, done pulse, ps2d released, `tx_idle`=1.
5. Second `wr_ps2` with 0x55 during frame 0xED → ignored; the device receives 0xED only, and exactly one done pulse occurs.
6. Reset asserted after F5 → next cycle both lines released, `tx_idle`=1, `tx_err`=0, no done pulse; a following write of 0xF4 completes normally.
